// File: rtl/led_xmit.sv
// led_xmit: byte-serial LED/IR line transmitter.
// Each byte is sent LSB first as eight pulse-width cells: every cell starts
// with an active mark (long for a 1, short for a 0) followed by a space that
// pads the cell to BIT_PERIOD cycles, and the byte ends with GAP idle cycles.
// Build option: define LED_XMIT_CARRIER_EN to modulate the mark with a
// carrier (output 0 when inactive, toggling every CARRIER_HALF during mark).
// Without it the output is baseband (idle 1, mark 0) and no carrier logic exists.
//
// Handshake: send is a request qualified by ready. A byte is accepted on a
// rising clk edge where ready=1 and send=1; data is captured on that edge.
// While ready=0, send is ignored and never queued. done pulses for one cycle
// in the last GAP cycle; ready returns in the following cycle.
module led_xmit #(
  parameter int BIT_PERIOD   = 84000,
  parameter int ONE_MARK     = 60000,
  parameter int ZERO_MARK    = 20000,
  parameter int GAP          = 100000,
  parameter int CARRIER_HALF = 1316
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       send,
  output logic       ready,
  output logic       done,
  output logic       led_xmit_out,
  output logic [1:0] state_dbg
);

  localparam int MAXN = (BIT_PERIOD > GAP) ? BIT_PERIOD : GAP;
  localparam int CW   = ($clog2(MAXN) > 17) ? $clog2(MAXN) : 17;

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] ONE_LAST  = CW'(ONE_MARK - 1);
  localparam logic [CW-1:0] ZERO_LAST = CW'(ZERO_MARK - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);

  // Marks must fit inside a cell, and every length must be at least one cycle.
  if (ZERO_MARK < 1 || ONE_MARK < 1 || ONE_MARK >= BIT_PERIOD ||
      ZERO_MARK >= BIT_PERIOD || GAP < 1 || CARRIER_HALF < 1) begin : g_param_check
    $error("led_xmit: invalid timing parameters");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MARK  = 2'd1,
    S_SPACE = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;        // cycles since start of cell (MARK+SPACE) or GAP
  logic [2:0]    idx;        // bit currently on the line
  logic [7:0]    shreg;      // bit 0 is the bit currently on the line
  logic [CW-1:0] mark_last;
  logic          cell_end;

  assign mark_last = shreg[0] ? ONE_LAST : ZERO_LAST;
  assign cell_end  = (cnt == BIT_LAST);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state decode and Moore outputs.
  always_comb begin
    next_state = state;
    ready      = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (send) next_state = S_MARK;
      end
      S_MARK: begin
        if (cnt == mark_last) next_state = S_SPACE;
      end
      S_SPACE: begin
        if (cell_end) next_state = (idx == 3'd7) ? S_GAP : S_MARK;
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          done       = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Cycle counter, bit index and shift register; the counter runs through
  // MARK into SPACE so a whole cell is measured from the start of its mark.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (send) begin
            shreg <= data;
            idx   <= '0;
            cnt   <= '0;
          end
        end
        S_MARK: cnt <= cnt + 1'b1;
        S_SPACE: begin
          if (cell_end) begin
            cnt   <= '0;
            shreg <= shreg >> 1;
            if (idx != 3'd7) idx <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) cnt <= '0;
          else                 cnt <= cnt + 1'b1;
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign state_dbg = state;

`ifdef LED_XMIT_CARRIER_EN
  localparam int CHW = ($clog2(CARRIER_HALF) < 1) ? 1 : $clog2(CARRIER_HALF);
  localparam logic [CHW-1:0] CH_LAST = CHW'(CARRIER_HALF - 1);

  logic           carrier;
  logic [CHW-1:0] ccnt;

  // Carrier phase: restarts high at every mark entry, toggles each half period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carrier <= 1'b0;
      ccnt    <= '0;
    end else if (next_state == S_MARK && state != S_MARK) begin
      carrier <= 1'b1;
      ccnt    <= '0;
    end else if (state == S_MARK) begin
      if (ccnt == CH_LAST) begin
        ccnt    <= '0;
        carrier <= ~carrier;
      end else begin
        ccnt <= ccnt + 1'b1;
      end
    end
  end

  assign led_xmit_out = (state == S_MARK) & carrier;
`else
  assign led_xmit_out = (state != S_MARK);
`endif

endmodule

// File: tb/tb_led_xmit.sv
// tb_led_xmit: directed bench for led_xmit with shortened timing parameters.
// A frame-level model expands each accepted byte into its expected per-cycle
// {out, ready, done} sequence; one process compares it against the DUT every
// cycle, and a few literal checks pin frame length and mark totals.
module tb_led_xmit;

  localparam int BP   = 20;
  localparam int ONE  = 12;
  localparam int ZERO = 5;
  localparam int GAPC = 25;
  localparam int CH   = 3;
  localparam int FRAME_LEN = 8 * BP + GAPC;  // 185: acceptance to done, inclusive of done cycle

`ifdef LED_XMIT_CARRIER_EN
  localparam logic IDLE_LVL = 1'b0;
`else
  localparam logic IDLE_LVL = 1'b1;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] data;
  logic       send;
  logic       ready;
  logic       done;
  logic       led_xmit_out;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;

  led_xmit #(
    .BIT_PERIOD  (BP),
    .ONE_MARK    (ONE),
    .ZERO_MARK   (ZERO),
    .GAP         (GAPC),
    .CARRIER_HALF(CH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .data        (data),
    .send        (send),
    .ready       (ready),
    .done        (done),
    .led_xmit_out(led_xmit_out),
    .state_dbg   (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [2:0] exp_q[$];   // {out, ready, done} per cycle
  int ncyc     = 0;
  int acc_n    = 0;
  int done_n   = 0;
  int restart  = 0;
  int done_cnt = 0;
  int last_len = 0;
  int low_cnt  = 0;
  int last_low = 0;
  logic [2:0] exp_v;
  logic [2:0] act_v;

  function automatic logic mark_level(input int c);
`ifdef LED_XMIT_CARRIER_EN
    return ((c / CH) % 2) == 0;
`else
    return 1'b0;
`endif
  endfunction

  // Expand one byte into its full expected waveform.
  function automatic void build_frame(input logic [7:0] d);
    for (int b = 0; b < 8; b++) begin
      int m;
      m = d[b] ? ONE : ZERO;
      for (int c = 0; c < BP; c++)
        exp_q.push_back({(c < m) ? mark_level(c) : IDLE_LVL, 1'b0, 1'b0});
    end
    for (int g = 0; g < GAPC; g++)
      exp_q.push_back({IDLE_LVL, 1'b0, (g == GAPC - 1)});
  endfunction

  // Per-cycle compare against the model, plus frame statistics.
  always @(negedge clk) begin
    ncyc++;
    act_v = {led_xmit_out, ready, done};
    if (reset) begin
      exp_q.delete();
      exp_v = {IDLE_LVL, 1'b1, 1'b0};
    end else if (exp_q.size() == 0) begin
      exp_v = {IDLE_LVL, 1'b1, 1'b0};
      if (send) begin
        restart = ncyc - done_n;
        acc_n   = ncyc;
        build_frame(data);
      end
    end else begin
      exp_v = exp_q.pop_front();
    end
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL cycle_check cyc=%0d got{out,ready,done}=%b want=%b", ncyc, act_v, exp_v);
    end
    if (led_xmit_out === 1'b0) low_cnt++;
    if (done === 1'b1) begin
      done_cnt++;
      last_len = ncyc - acc_n;
      last_low = low_cnt;
      low_cnt  = 0;
      done_n   = ncyc;
    end
  end

  // Driver and check tasks
  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    data    = d;
    send    = 1'b1;
    low_cnt = 0;
    @(posedge clk); #1;
    send = 1'b0;
    data = ~d;   // must not disturb the frame in flight
  endtask

  task automatic wait_done(input string name, input int limit);
    int start;
    int i;
    start = done_cnt;
    i = 0;
    while (done_cnt == start && i < limit) begin
      @(posedge clk);
      i++;
    end
    #1;
    check({name, "_timeout"}, (done_cnt != start) ? 1 : 0, 1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] tbl_byte[3] = '{8'h00, 8'hFF, 8'h5A};
  int         tbl_low [3] = '{8 * ZERO, 8 * ONE, 4 * ONE + 4 * ZERO};

  // Directed sequence
  initial begin
    int d0;
    reset = 1'b0;
    data  = 8'h00;
    send  = 1'b0;
    #1 reset = 1'b1;
    idle_cycles(3);
    check("reset_ready", int'(ready), 1);
    check("reset_done", int'(done), 0);
    check("reset_out", int'(led_xmit_out), int'(IDLE_LVL));
    reset = 1'b0;
    idle_cycles(2);

    // 0xA5: four long and four short marks
    send_byte(8'hA5);
    wait_done("a5", FRAME_LEN + 20);
    check("a5_len", last_len, FRAME_LEN);
`ifndef LED_XMIT_CARRIER_EN
    check("a5_low", last_low, 4 * ONE + 4 * ZERO);
`endif
    idle_cycles(3);

    // Pattern table
    for (int k = 0; k < 3; k++) begin
      send_byte(tbl_byte[k]);
      wait_done("tbl", FRAME_LEN + 20);
      check("tbl_len", last_len, FRAME_LEN);
`ifndef LED_XMIT_CARRIER_EN
      check("tbl_low", last_low, tbl_low[k]);
`endif
      idle_cycles(2 + k);
    end

    // 0x3C with a stray SEND during bit 3
    d0 = done_cnt;
    send_byte(8'h3C);
    idle_cycles(3 * BP + 2);
    data = 8'hFF;
    send = 1'b1;
    idle_cycles(1);
    send = 1'b0;
    wait_done("3c", FRAME_LEN);
    idle_cycles(BP * 2);
    check("3c_done_count", done_cnt - d0, 1);
    check("3c_len", last_len, FRAME_LEN);

    // Reset during the mark of bit 4, then 0x81
    d0 = done_cnt;
    send_byte(8'hFF);
    idle_cycles(4 * BP + 2);
    reset = 1'b1;
    #1;
    check("abort_out", int'(led_xmit_out), int'(IDLE_LVL));
    check("abort_ready", int'(ready), 1);
    check("abort_done", int'(done), 0);
    idle_cycles(2);
    reset = 1'b0;
    idle_cycles(3);
    check("abort_no_done", done_cnt - d0, 0);
    send_byte(8'h81);
    wait_done("post_reset", FRAME_LEN + 20);
    check("post_reset_len", last_len, FRAME_LEN);
`ifndef LED_XMIT_CARRIER_EN
    check("post_reset_low", last_low, 2 * ONE + 6 * ZERO);
`endif
    idle_cycles(2);

    // SEND held high with 0x12: back-to-back frames
    d0 = done_cnt;
    data = 8'h12;
    send = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 3 * FRAME_LEN && done_cnt - d0 < 2; i++) @(posedge clk);
    #1;
    send = 1'b0;
    check("held_frames", done_cnt - d0, 2);
    check("held_restart", restart, 1);
    check("held_len", last_len, FRAME_LEN);
`ifndef LED_XMIT_CARRIER_EN
    check("held_low", last_low, 2 * ONE + 6 * ZERO);
`endif
    idle_cycles(10);
    check("final_idle_ready", int'(ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
